// File: rtl/param_counter.sv
// param_counter: up/down counter with programmable terminal value, wrap or saturate mode,
// a one-cycle event pulse and sticky overflow/underflow flags.
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset; clears count and all flags
//   clear    - synchronous clear of count and flags (highest priority)
//   load     - synchronous load of load_val, clamped to MAX_VAL
//   load_val - value used by load
//   en       - count enable
//   up       - direction, 1 = up, 0 = down
//   count    - registered count, never above MAX_VAL
//   wrap     - one-cycle pulse coincident with the count after a wrap/saturation event
//   ovf/unf  - sticky flags for an up-count at MAX_VAL / a down-count at 0
module param_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);
  localparam logic [WIDTH-1:0] MAX  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               SAT  = SATURATE != 0;
  logic [WIDTH-1:0] count_q, count_d, step_val, load_clamp;
  logic             wrap_q, wrap_d, ovf_q, ovf_d, unf_q, unf_d;
  logic             hit_max, hit_zero;
  // an event only counts when en actually drives the update (no clear, no load)
  assign hit_max    = en && up && (count_q == MAX);
  assign hit_zero   = en && !up && (count_q == ZERO);
  assign load_clamp = (load_val > MAX) ? MAX : load_val;
  always_comb begin
    step_val = up ? (hit_max  ? (SAT ? MAX : ZERO) : count_q + ONE)
                  : (hit_zero ? (SAT ? ZERO : MAX) : count_q - ONE);
    count_d  = clear ? ZERO : load ? load_clamp : en ? step_val : count_q;
    wrap_d   = !clear && !load && (hit_max || hit_zero);
    ovf_d    = !clear && (ovf_q || (!load && hit_max));
    unf_d    = !clear && (unf_q || (!load && hit_zero));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed table and sequence checks for param_counter in three configurations.
module tb_param_counter;
  typedef struct packed {
    logic       clear;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] lv;
  } ctl_t;
  typedef struct {
    logic       clear, load, en, up;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       w, o, u;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  ctl_t cw = '0, cs = '0, ce = '0;
  logic [3:0] cnt_w, cnt_s;
  logic [7:0] cnt_e;
  logic       wr_w, ov_w, un_w, wr_s, ov_s, un_s, wr_e, ov_e, un_e;
  int total = 0;
  int bad = 0;
  vec_t tab[$];
  always #5 clk = ~clk;
  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_w (
    .clk(clk), .reset(reset), .clear(cw.clear), .load(cw.load), .load_val(cw.lv[3:0]),
    .en(cw.en), .up(cw.up), .count(cnt_w), .wrap(wr_w), .ovf(ov_w), .unf(un_w));
  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .clear(cs.clear), .load(cs.load), .load_val(cs.lv[3:0]),
    .en(cs.en), .up(cs.up), .count(cnt_s), .wrap(wr_s), .ovf(ov_s), .unf(un_s));
  param_counter #(.WIDTH(8), .SATURATE(0)) u_e (
    .clk(clk), .reset(reset), .clear(ce.clear), .load(ce.load), .load_val(ce.lv),
    .en(ce.en), .up(ce.up), .count(cnt_e), .wrap(wr_e), .ovf(ov_e), .unf(un_e));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk4(input string name, input logic [31:0] c, input logic w, input logic o,
                      input logic u, input logic [31:0] ec, input logic ew, input logic eo,
                      input logic eu);
    chk({name, ".count"}, c, ec);
    chk({name, ".wrap"}, {31'd0, w}, {31'd0, ew});
    chk({name, ".ovf"}, {31'd0, o}, {31'd0, eo});
    chk({name, ".unf"}, {31'd0, u}, {31'd0, eu});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t v(input logic c, l, e, d, input logic [3:0] lv, cnt,
                             input logic w, o, u);
    v.clear = c; v.load = l; v.en = e; v.up = d; v.lv = lv;
    v.cnt = cnt; v.w = w; v.o = o; v.u = u;
  endfunction
  function automatic ctl_t mk(input logic c, l, e, d, input logic [7:0] lv);
    mk = '{clear: c, load: l, en: e, up: d, lv: lv};
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tab.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) tab.push_back(v(0, 0, 1, 1, 0, 4'(i), 0, 0, 0));
    tab.push_back(v(0, 0, 1, 1, 0, 0, 1, 1, 0));
    tab.push_back(v(0, 0, 1, 1, 0, 1, 0, 1, 0));
    tab.push_back(v(0, 0, 1, 1, 0, 2, 0, 1, 0));
    tab.push_back(v(0, 1, 1, 1, 14, 9, 0, 1, 0));
    tab.push_back(v(0, 0, 0, 1, 0, 9, 0, 1, 0));
    tab.push_back(v(0, 0, 1, 0, 0, 8, 0, 1, 0));
    tab.push_back(v(0, 0, 1, 1, 0, 9, 0, 1, 0));
    tab.push_back(v(0, 0, 1, 1, 0, 0, 1, 1, 0));
    tab.push_back(v(0, 0, 1, 0, 0, 9, 1, 1, 1));
    tab.push_back(v(0, 1, 0, 0, 5, 5, 0, 1, 1));
    tab.push_back(v(1, 1, 1, 1, 3, 0, 0, 0, 0));
    tab.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(v(0, 1, 0, 0, 10, 9, 0, 0, 0));
    tab.push_back(v(0, 0, 1, 0, 0, 8, 0, 0, 0));
    #10;
    reset = 1'b0;
    #1;
    chk4("reset_async", cnt_w, wr_w, ov_w, un_w, 0, 0, 0, 0);
    chk4("reset_async_s", cnt_s, wr_s, ov_s, un_s, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    cw = mk(0, 0, 1, 1, 0);
    step();
    chk4("first_up", cnt_w, wr_w, ov_w, un_w, 1, 0, 0, 0);
    foreach (tab[i]) begin
      cw = mk(tab[i].clear, tab[i].load, tab[i].en, tab[i].up, {4'd0, tab[i].lv});
      step();
      chk4($sformatf("vec%0d", i), cnt_w, wr_w, ov_w, un_w,
           tab[i].cnt, tab[i].w, tab[i].o, tab[i].u);
    end
    cw = mk(0, 0, 1, 1, 0);
    #3;
    reset = 1'b0;
    #1;
    chk4("midcount_reset", cnt_w, wr_w, ov_w, un_w, 0, 0, 0, 0);
    cw = mk(0, 1, 1, 1, 7);
    step();
    chk4("reset_ignores_inputs", cnt_w, wr_w, ov_w, un_w, 0, 0, 0, 0);
    reset = 1'b1;
    cw = mk(0, 0, 1, 1, 0);
    step();
    chk4("resume_from_zero", cnt_w, wr_w, ov_w, un_w, 1, 0, 0, 0);
    cw = '0;
    cs = mk(0, 1, 0, 0, 2);
    step();
    chk4("sat_load2", cnt_s, wr_s, ov_s, un_s, 2, 0, 0, 0);
    cs = mk(0, 0, 1, 0, 0);
    step();
    chk4("sat_dn1", cnt_s, wr_s, ov_s, un_s, 1, 0, 0, 0);
    step();
    chk4("sat_dn2", cnt_s, wr_s, ov_s, un_s, 0, 0, 0, 0);
    step();
    chk4("sat_dn3", cnt_s, wr_s, ov_s, un_s, 0, 1, 0, 1);
    step();
    chk4("sat_dn4", cnt_s, wr_s, ov_s, un_s, 0, 1, 0, 1);
    cs = mk(0, 1, 1, 1, 15);
    step();
    chk4("sat_load15", cnt_s, wr_s, ov_s, un_s, 9, 0, 0, 1);
    cs = mk(0, 0, 1, 1, 0);
    step();
    chk4("sat_up1", cnt_s, wr_s, ov_s, un_s, 9, 1, 1, 1);
    step();
    chk4("sat_up2", cnt_s, wr_s, ov_s, un_s, 9, 1, 1, 1);
    cs = '0;
    step();
    chk4("sat_idle", cnt_s, wr_s, ov_s, un_s, 9, 0, 1, 1);
    ce = mk(0, 1, 0, 0, 8'd255);
    step();
    chk4("w8_load255", cnt_e, wr_e, ov_e, un_e, 255, 0, 0, 0);
    ce = mk(0, 0, 1, 1, 0);
    step();
    chk4("w8_up_wrap", cnt_e, wr_e, ov_e, un_e, 0, 1, 1, 0);
    ce = mk(0, 0, 1, 0, 0);
    step();
    chk4("w8_dn_wrap", cnt_e, wr_e, ov_e, un_e, 255, 1, 1, 1);
    step();
    chk4("w8_dn", cnt_e, wr_e, ov_e, un_e, 254, 0, 1, 1);
    ce = mk(1, 0, 0, 0, 0);
    step();
    chk4("w8_clear", cnt_e, wr_e, ov_e, un_e, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
